// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NREQ
// producers. One producer owns the port at a time for up to BURST writes;
// writes stall (without losing data) while the FIFO reports full.
module fifo_wr_arbiter #(
    parameter int N     = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] req_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    input  logic              fifo_status_full,
    output logic              fifo_wr_en,
    output logic [N-1:0]      fifo_data_in,
    output logic              busy
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [OW-1:0]   last_owner_reg, last_owner_next;
    logic [CW-1:0]   burst_cnt_reg, burst_cnt_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic            busy_reg, busy_next;

    logic [N-1:0]    req_word [NREQ];
    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic            owner_req;
    logic            write_en;
    logic            burst_done;

    // Unpack the flat producer data bus into one word per producer.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_word[gi] = req_data[gi*N +: N];
        end
    endgenerate

    // Round-robin pick: first requester after last_owner, wrapping around.
    // The loop runs from farthest to nearest so the nearest candidate wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[OW'((int'(last_owner_reg) + k) % NREQ)]) begin
                pick_valid = 1'b1;
                pick_idx   = OW'((int'(last_owner_reg) + k) % NREQ);
            end
        end
    end

    // A write happens only while granted, the owner still requests, the FIFO
    // has room and no reset is being applied in this cycle.
    assign owner_req  = req[owner_reg];
    assign write_en   = (state_reg == GRANT) && owner_req && !fifo_status_full && !rst;
    assign burst_done = (burst_cnt_reg == CW'(BURST - 1));

    assign fifo_wr_en   = write_en;
    assign fifo_data_in = ((state_reg == GRANT) && !rst) ? req_word[owner_reg] : '0;
    assign grant        = grant_reg;
    assign busy         = busy_reg;

    // Acknowledge only the owner, in the same cycle its word is written.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
            assign ack[gi] = write_en && (owner_reg == OW'(gi));
        end
    endgenerate

    // Next-state logic: arbitrate in IDLE, count writes and release in GRANT.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        burst_cnt_next  = burst_cnt_reg;
        grant_next      = grant_reg;
        busy_next       = busy_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next     = GRANT;
                    owner_next     = pick_idx;
                    burst_cnt_next = '0;
                    grant_next     = NREQ'(1) << pick_idx;
                    busy_next      = 1'b1;
                end
            end
            GRANT: begin
                if (write_en) begin
                    burst_cnt_next = burst_cnt_reg + CW'(1);
                end
                // Release when the owner withdraws or its burst is used up.
                if (!owner_req || (write_en && burst_done)) begin
                    state_next      = IDLE;
                    grant_next      = '0;
                    busy_next       = 1'b0;
                    last_owner_next = owner_reg;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State registers; reset gives producer 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= OW'(NREQ - 1);
            burst_cnt_reg  <= '0;
            grant_reg      <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            burst_cnt_reg  <= burst_cnt_next;
            grant_reg      <= grant_next;
            busy_reg       <= busy_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int N     = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic              fifo_status_full;
    logic              fifo_wr_en;
    logic [N-1:0]      fifo_data_in;
    logic              busy;

    fifo_wr_arbiter #(.N(N), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .req_data         (req_data),
        .grant            (grant),
        .ack              (ack),
        .fifo_status_full (fifo_status_full),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_data_in     (fifo_data_in),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Producer state: pending words per producer, plus a withdraw mask.
    logic [N-1:0]    pq [NREQ][$];
    logic [NREQ-1:0] drop;

    // Reference model: owner (-1 = no owner), last owner, writes in burst.
    int m_owner;
    int m_last;
    int m_cnt;

    // Observations from the most recent cycle.
    logic [NREQ-1:0] obs_grant, obs_ack, prev_grant;
    logic            obs_wr, obs_busy;
    logic [N-1:0]    fifo_q [$];
    logic [NREQ-1:0] gq [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive producers, check outputs, advance the model.
    task automatic run_cycle(input logic r, input logic f);
        logic [NREQ-1:0]   rq;
        logic [NREQ*N-1:0] rd;
        logic [NREQ-1:0]   e_grant, e_ack;
        logic              e_wr, e_busy;
        logic [N-1:0]      e_data;
        rq = '0;
        rd = '0;
        for (int i = 0; i < NREQ; i++) begin
            rq[i] = (pq[i].size() > 0) && !drop[i];
            if (pq[i].size() > 0) rd[i*N +: N] = pq[i][0];
        end
        rst = r;
        req = rq;
        req_data = rd;
        fifo_status_full = f;
        #2;
        e_grant = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        e_busy  = (m_owner >= 0);
        e_wr    = !r && (m_owner >= 0) && rq[m_owner] && !f;
        e_data  = (!r && m_owner >= 0) ? rd[m_owner*N +: N] : '0;
        e_ack   = e_wr ? (NREQ'(1) << m_owner) : '0;
        check_val("grant", 64'(grant), 64'(e_grant));
        check_val("busy", 64'(busy), 64'(e_busy));
        check_val("wr_en", 64'(fifo_wr_en), 64'(e_wr));
        check_val("data_in", 64'(fifo_data_in), 64'(e_data));
        check_val("ack", 64'(ack), 64'(e_ack));
        prev_grant = obs_grant;
        obs_grant  = grant;
        obs_ack    = ack;
        obs_wr     = fifo_wr_en;
        obs_busy   = busy;
        if (obs_grant != '0 && prev_grant == '0) gq.push_back(obs_grant);
        if (fifo_wr_en === 1'b1) begin
            fifo_q.push_back(fifo_data_in);
            $display("write t=%0t ack=%b data=%02h", $time, ack, fifo_data_in);
        end
        // Model update following the arbitration rules.
        if (r) begin
            m_owner = -1;
            m_last  = NREQ - 1;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (m_owner < 0 && rq[(m_last + k) % NREQ]) begin
                    m_owner = (m_last + k) % NREQ;
                    m_cnt   = 0;
                end
            end
        end else begin
            int o;
            o = m_owner;
            if (e_wr) begin
                void'(pq[o].pop_front());
                m_cnt++;
            end
            if (!rq[o] || (e_wr && m_cnt == BURST)) begin
                m_last  = o;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) pq[i].delete();
        drop = '0;
        fifo_q.delete();
        gq.delete();
    endtask

    task automatic reset_dut();
        clear_all();
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_data = '0;
        fifo_status_full = 1'b0;
        drop = '0;
        obs_grant = '0;
        prev_grant = '0;
        m_owner = -1;
        m_last  = NREQ - 1;
        m_cnt   = 0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset held with all producers requesting.
        clear_all();
        for (int i = 0; i < NREQ; i++) pq[i].push_back(8'hA0 + 8'(i));
        for (int c = 0; c < 3; c++) begin
            run_cycle(1'b1, 1'b0);
            check_val("rst_grant", 64'(obs_grant), 64'h0);
            check_val("rst_wr", 64'(obs_wr), 64'h0);
            check_val("rst_ack", 64'(obs_ack), 64'h0);
            check_val("rst_busy", 64'(obs_busy), 64'h0);
        end

        // Single producer: two-word burst, one idle cycle, re-grant.
        reset_dut();
        pq[2].push_back(8'h11);
        pq[2].push_back(8'h12);
        pq[2].push_back(8'h13);
        run_cycle(1'b0, 1'b0);
        check_val("single_idle0", 64'(obs_grant), 64'h0);
        run_cycle(1'b0, 1'b0);
        check_val("single_grant", 64'(obs_grant), 64'h4);
        check_val("single_ack1", 64'(obs_ack), 64'h4);
        run_cycle(1'b0, 1'b0);
        check_val("single_ack2", 64'(obs_ack), 64'h4);
        run_cycle(1'b0, 1'b0);
        check_val("single_gap", 64'(obs_grant), 64'h0);
        run_cycle(1'b0, 1'b0);
        check_val("single_regrant", 64'(obs_grant), 64'h4);
        check_val("single_w0", 64'(fifo_q[0]), 64'h11);
        check_val("single_w1", 64'(fifo_q[1]), 64'h12);

        // Round robin with all four producers requesting continuously.
        reset_dut();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 6; k++) pq[i].push_back(8'(i*16 + k));
        for (int c = 0; c < 15; c++) run_cycle(1'b0, 1'b0);
        begin
            logic [NREQ-1:0] exp_g [5];
            logic [N-1:0]    exp_w [8];
            exp_g = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
            exp_w = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};
            check_val("rr_ngrants", 64'(gq.size() >= 5), 64'h1);
            for (int j = 0; j < 5; j++) check_val("rr_order", 64'(gq[j]), 64'(exp_g[j]));
            for (int j = 0; j < 8; j++) check_val("rr_word", 64'(fifo_q[j]), 64'(exp_w[j]));
        end

        // FIFO full stall during producer 1's grant.
        reset_dut();
        pq[1].push_back(8'h21);
        pq[1].push_back(8'h22);
        run_cycle(1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            run_cycle(1'b0, 1'b1);
            check_val("full_grant", 64'(obs_grant), 64'h2);
            check_val("full_wr", 64'(obs_wr), 64'h0);
            check_val("full_ack", 64'(obs_ack), 64'h0);
        end
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
        check_val("full_after", 64'(obs_grant), 64'h0);
        check_val("full_nwrites", 64'(fifo_q.size()), 64'd2);
        check_val("full_w0", 64'(fifo_q[0]), 64'h21);
        check_val("full_w1", 64'(fifo_q[1]), 64'h22);

        // Early release by producer 3, next grant wraps to producer 0.
        reset_dut();
        pq[3].push_back(8'h31);
        pq[3].push_back(8'h32);
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
        check_val("early_ack", 64'(obs_ack), 64'h8);
        drop[3] = 1'b1;
        pq[0].push_back(8'h40);
        pq[1].push_back(8'h41);
        run_cycle(1'b0, 1'b0);
        check_val("early_nowr", 64'(obs_wr), 64'h0);
        run_cycle(1'b0, 1'b0);
        check_val("early_idle", 64'(obs_grant), 64'h0);
        run_cycle(1'b0, 1'b0);
        check_val("early_wrap", 64'(obs_grant), 64'h1);

        // Reset in the cycle of producer 0's second write.
        reset_dut();
        pq[0].push_back(8'h51);
        pq[0].push_back(8'h52);
        pq[1].push_back(8'h61);
        pq[3].push_back(8'h71);
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
        check_val("mid_first", 64'(obs_ack), 64'h1);
        run_cycle(1'b1, 1'b0);
        check_val("mid_wr", 64'(obs_wr), 64'h0);
        check_val("mid_ack", 64'(obs_ack), 64'h0);
        pq[0].delete();
        run_cycle(1'b0, 1'b0);
        check_val("mid_idle", 64'(obs_grant), 64'h0);
        run_cycle(1'b0, 1'b0);
        check_val("mid_regrant", 64'(obs_grant), 64'h2);

        // Randomized traffic with full stalls, withdrawals and resets.
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            logic r, f;
            for (int i = 0; i < NREQ; i++) begin
                if (pq[i].size() == 0 && $urandom_range(99) < 30)
                    pq[i].push_back(8'($urandom));
                if (pq[i].size() < 3 && $urandom_range(99) < 10)
                    pq[i].push_back(8'($urandom));
                drop[i] = ($urandom_range(99) < 5);
            end
            f = ($urandom_range(99) < 25);
            r = ($urandom_range(199) == 0);
            run_cycle(r, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
